regfile_wb_arbiter: RTL and testbench

//   Writer side of the register-file write port. Merges results from the single-cycle
//   ALU and the multi-cycle memory/load unit into one ordered write stream.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/wb_fifo.sv | 76 +++++++
 rtl/regfile_wb_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the register-file writeback path: register geometry,
// the queued write entry and the arbiter grant encoding.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef enum logic {
        ALU = 1'b0,
        MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of pending register writes. Also exposes which slots
// hold live entries and their destination registers for the pending mask.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  wb_entry_t                        pushEntry,
    input  logic                             pop,
    output wb_entry_t                        headEntry,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH):0]           count,
    output logic [DEPTH-1:0]                 entryValid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] entryRd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] offset;
    logic             doPush;
    logic             doPop;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign doPush    = push && !full;
    assign doPop     = pop && !empty;
    assign headEntry = mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushEntry;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        offset     = '0;
        entryValid = '0;
        entryRd    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset        = PTR_W'(i) - rdPtr;
            entryValid[i] = ({1'b0, offset} < count);
            entryRd[i]    = mem[i].rd;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port front end: round-robin merge of ALU and memory
// results into an ordered FIFO, drained one write per cycle.
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [REG_ADDR_W-1:0]   alu_rd,
    input  logic [XLEN-1:0]         alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [REG_ADDR_W-1:0]   mem_rd,
    input  logic [XLEN-1:0]         mem_data,
    input  logic                    wb_stall,
    output logic [REG_ADDR_W-1:0]   rd,
    output logic [XLEN-1:0]         writeData,
    output logic                    regWrite,
    output logic [2**REG_ADDR_W-1:0] pending_mask,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    grant_e                          lastGrant;
    grant_e                          lastGrantNext;
    logic                            grantAlu;
    logic                            grantMem;
    logic                            full;
    logic                            empty;
    logic                            push;
    wb_entry_t                       pushEntry;
    wb_entry_t                       headEntry;
    logic [DEPTH-1:0]                entryValid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entryRd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant <= MEM;
        end else begin
            lastGrant <= lastGrantNext;
        end
    end

    // Round-robin only matters on conflict cycles; lone requesters always win.
    always_comb begin
        grantAlu      = 1'b0;
        grantMem      = 1'b0;
        lastGrantNext = lastGrant;
        if (alu_valid && mem_valid) begin
            if (lastGrant == MEM) begin
                grantAlu = 1'b1;
            end else begin
                grantMem = 1'b1;
            end
            if (!full) begin
                lastGrantNext = grantAlu ? ALU : MEM;
            end
        end else begin
            grantAlu = alu_valid;
            grantMem = mem_valid;
        end
    end

    assign alu_ready = grantAlu && !full && rst_n;
    assign mem_ready = grantMem && !full && rst_n;

    // Writes to x0 complete the handshake but are never queued.
    always_comb begin
        pushEntry = '0;
        push      = 1'b0;
        if (alu_ready) begin
            pushEntry.rd   = alu_rd;
            pushEntry.data = alu_data;
            push           = (alu_rd != '0);
        end else if (mem_ready) begin
            pushEntry.rd   = mem_rd;
            pushEntry.data = mem_data;
            push           = (mem_rd != '0);
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pushEntry  (pushEntry),
        .pop        (regWrite),
        .headEntry  (headEntry),
        .full       (full),
        .empty      (empty),
        .count      (fifo_count),
        .entryValid (entryValid),
        .entryRd    (entryRd)
    );

    assign regWrite  = !empty && !wb_stall;
    assign rd        = empty ? '0 : headEntry.rd;
    assign writeData = empty ? '0 : headEntry.data;

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i]) begin
                pending_mask[entryRd[i]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_regfile_wb_arbiter;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     alu_valid = 1'b0;
    logic                     alu_ready;
    logic [REG_ADDR_W-1:0]    alu_rd = '0;
    logic [XLEN-1:0]          alu_data = '0;
    logic                     mem_valid = 1'b0;
    logic                     mem_ready;
    logic [REG_ADDR_W-1:0]    mem_rd = '0;
    logic [XLEN-1:0]          mem_data = '0;
    logic                     wb_stall = 1'b0;
    logic [REG_ADDR_W-1:0]    rd;
    logic [XLEN-1:0]          writeData;
    logic                     regWrite;
    logic [2**REG_ADDR_W-1:0] pending_mask;
    logic [$clog2(DEPTH):0]   fifo_count;

    int checks = 0;
    int failures = 0;

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .wb_stall     (wb_stall),
        .rd           (rd),
        .writeData    (writeData),
        .regWrite     (regWrite),
        .pending_mask (pending_mask),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    // Hard time limit so the bench always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        wb_stall  = 1'b0;
        alu_rd    = '0;
        mem_rd    = '0;
        alu_data  = '0;
        mem_data  = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        nextCycle();
    endtask

    task automatic test_reset();
        bit sawWrite = 1'b0;
        doReset();
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1;
            alu_rd    = REG_ADDR_W'(i + 1);
            alu_data  = 32'h5000 + i;
            nextCycle();
        end
        #1;
        checks++;
        if (fifo_count !== 3) begin
            failures++;
            $display("[TB] FAIL reset_prefill_count: got %0d expected 3", fifo_count);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (regWrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_regWrite: got %b expected 0", regWrite);
        end
        checks++;
        if (pending_mask !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mask: got %h expected 0", pending_mask);
        end
        checks++;
        if (fifo_count !== 0) begin
            failures++;
            $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count);
        end
        checks++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready: got alu=%b mem=%b expected 0 0", alu_ready, mem_ready);
        end
        alu_valid = 1'b0;
        wb_stall  = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            if (regWrite) sawWrite = 1'b1;
        end
        checks++;
        if (sawWrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_no_write: got write=%b expected 0", sawWrite);
        end
    endtask

    task automatic test_single_alu();
        doReset();
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEADBEEF;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_ready: got %b expected 1", alu_ready);
        end
        nextCycle();
        alu_valid = 1'b0;
        #1;
        checks++;
        if (regWrite !== 1'b1 || rd !== 5'd5 || writeData !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL single_write: got we=%b rd=%0d data=%h expected 1 5 deadbeef",
                     regWrite, rd, writeData);
        end
        checks++;
        if (pending_mask[5] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_mask_set: got %b expected 1", pending_mask[5]);
        end
        nextCycle();
        checks++;
        if (pending_mask[5] !== 1'b0 || regWrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_mask_clear: got mask=%b we=%b expected 0 0",
                     pending_mask[5], regWrite);
        end
    endtask

    task automatic test_conflict();
        wb_entry_t got[$];
        wb_entry_t tmp;
        int aIdx = 0;
        int mIdx = 0;
        logic [REG_ADDR_W-1:0] expRd [4];
        expRd[0] = 5'd1;
        expRd[1] = 5'd11;
        expRd[2] = 5'd2;
        expRd[3] = 5'd12;
        doReset();
        for (int c = 0; c < 4; c++) begin
            alu_valid = 1'b1;
            alu_rd    = REG_ADDR_W'(1 + aIdx);
            alu_data  = 32'h100 + 32'(1 + aIdx);
            mem_valid = 1'b1;
            mem_rd    = REG_ADDR_W'(11 + mIdx);
            mem_data  = 32'h200 + 32'(11 + mIdx);
            #1;
            checks++;
            if (alu_ready !== (c % 2 == 0) || mem_ready !== (c % 2 == 1)) begin
                failures++;
                $display("[TB] FAIL conflict_grant%0d: got alu=%b mem=%b expected alu=%b mem=%b",
                         c, alu_ready, mem_ready, (c % 2 == 0), (c % 2 == 1));
            end
            if (regWrite) begin
                tmp.rd = rd;
                tmp.data = writeData;
                got.push_back(tmp);
            end
            if (c % 2 == 0) aIdx++;
            else mIdx++;
            nextCycle();
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (regWrite) begin
                tmp.rd = rd;
                tmp.data = writeData;
                got.push_back(tmp);
            end
            nextCycle();
        end
        checks++;
        if (got.size() != 4) begin
            failures++;
            $display("[TB] FAIL conflict_retire_count: got %0d expected 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i].rd !== expRd[i] ||
                    got[i].data !== ((expRd[i] > 10 ? 32'h200 : 32'h100) + 32'(expRd[i]))) begin
                    failures++;
                    $display("[TB] FAIL conflict_order%0d: got rd=%0d data=%h expected rd=%0d",
                             i, got[i].rd, got[i].data, expRd[i]);
                end
            end
        end
    endtask

    task automatic test_full();
        doReset();
        wb_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1;
            alu_rd    = REG_ADDR_W'(21 + k);
            alu_data  = 32'hA0 + k;
            #1;
            checks++;
            if (alu_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL full_fill_ready%0d: got %b expected 1", k, alu_ready);
            end
            nextCycle();
        end
        alu_rd    = 5'd25;
        alu_data  = 32'hA5;
        mem_valid = 1'b1;
        mem_rd    = 5'd26;
        mem_data  = 32'hA6;
        #1;
        checks++;
        if (fifo_count !== 4 || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_block: got count=%0d alu=%b mem=%b expected 4 0 0",
                     fifo_count, alu_ready, mem_ready);
        end
        nextCycle();
        mem_valid = 1'b0;
        wb_stall  = 1'b0;
        #1;
        checks++;
        if (regWrite !== 1'b1 || rd !== 5'd21 || alu_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_no_popthrough: got we=%b rd=%0d alu_ready=%b expected 1 21 0",
                     regWrite, rd, alu_ready);
        end
        nextCycle();
        alu_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            #1;
            checks++;
            if (regWrite !== 1'b1 || rd !== REG_ADDR_W'(21 + k) || writeData !== 32'hA0 + k) begin
                failures++;
                $display("[TB] FAIL full_drain%0d: got we=%b rd=%0d data=%h expected 1 %0d %h",
                         k, regWrite, rd, writeData, 21 + k, 32'hA0 + k);
            end
            nextCycle();
        end
        alu_valid = 1'b1;
        #1;
        checks++;
        if (regWrite !== 1'b0 || alu_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_ready_back: got we=%b ready=%b expected 0 1", regWrite, alu_ready);
        end
        nextCycle();
        alu_valid = 1'b0;
        #1;
        checks++;
        if (regWrite !== 1'b1 || rd !== 5'd25) begin
            failures++;
            $display("[TB] FAIL full_after: got we=%b rd=%0d expected 1 25", regWrite, rd);
        end
        nextCycle();
    endtask

    task automatic test_x0();
        bit sawWrite = 1'b0;
        bit countBad = 1'b0;
        doReset();
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'h1234;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL x0_ready: got %b expected 1", alu_ready);
        end
        nextCycle();
        alu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (regWrite) sawWrite = 1'b1;
            if (fifo_count != 0 || pending_mask != '0) countBad = 1'b1;
            nextCycle();
        end
        checks++;
        if (sawWrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL x0_no_write: got write=%b expected 0", sawWrite);
        end
        checks++;
        if (countBad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL x0_count: got nonzero count/mask=%b expected 0", countBad);
        end
    endtask

    task automatic test_same_rd();
        logic [XLEN-1:0] lastData = '0;
        doReset();
        wb_stall  = 1'b1;
        alu_valid = 1'b1;
        alu_rd    = 5'd7;
        alu_data  = 32'd1;
        nextCycle();
        alu_valid = 1'b0;
        mem_valid = 1'b1;
        mem_rd    = 5'd7;
        mem_data  = 32'd2;
        #1;
        checks++;
        if (mem_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL samerd_mem_ready: got %b expected 1", mem_ready);
        end
        nextCycle();
        mem_valid = 1'b0;
        #1;
        checks++;
        if (fifo_count !== 2 || pending_mask[7] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL samerd_queued: got count=%0d mask7=%b expected 2 1",
                     fifo_count, pending_mask[7]);
        end
        wb_stall = 1'b0;
        #1;
        checks++;
        if (regWrite !== 1'b1 || writeData !== 32'd1 || pending_mask[7] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL samerd_first: got we=%b data=%0d mask7=%b expected 1 1 1",
                     regWrite, writeData, pending_mask[7]);
        end
        nextCycle();
        #1;
        checks++;
        if (regWrite !== 1'b1 || writeData !== 32'd2 || pending_mask[7] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL samerd_second: got we=%b data=%0d mask7=%b expected 1 2 1",
                     regWrite, writeData, pending_mask[7]);
        end
        if (regWrite) lastData = writeData;
        nextCycle();
        #1;
        checks++;
        if (pending_mask[7] !== 1'b0 || regWrite !== 1'b0 || lastData !== 32'd2) begin
            failures++;
            $display("[TB] FAIL samerd_final: got mask7=%b we=%b last=%0d expected 0 0 2",
                     pending_mask[7], regWrite, lastData);
        end
    endtask

    task automatic test_random();
        wb_entry_t q[$];
        wb_entry_t tmp;
        grant_e modelLast = MEM;
        bit aluTook = 1'b1;
        bit memTook = 1'b1;
        bit modelFull;
        bit expAlu;
        bit expMem;
        bit expWrite;
        logic [REG_ADDR_W-1:0] expRd;
        logic [XLEN-1:0] expData;
        logic [2**REG_ADDR_W-1:0] expMask;
        doReset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            // Sources only change payload once the previous offer was taken.
            if (!alu_valid || aluTook) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_rd    = REG_ADDR_W'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!mem_valid || memTook) begin
                mem_valid = ($urandom_range(0, 99) < 60);
                mem_rd    = REG_ADDR_W'($urandom_range(0, 31));
                mem_data  = $urandom;
            end
            wb_stall = ($urandom_range(0, 99) < 30);
            #1;
            modelFull = (q.size() == DEPTH);
            if (alu_valid && mem_valid) begin
                expAlu = (modelLast == MEM);
                expMem = !expAlu;
            end else begin
                expAlu = alu_valid;
                expMem = mem_valid;
            end
            expAlu   = expAlu && !modelFull;
            expMem   = expMem && !modelFull;
            expWrite = (q.size() != 0) && !wb_stall;
            expRd    = (q.size() != 0) ? q[0].rd : '0;
            expData  = (q.size() != 0) ? q[0].data : '0;
            expMask  = '0;
            foreach (q[i]) expMask[q[i].rd] = 1'b1;

            checks++;
            if (alu_ready !== expAlu) begin
                failures++;
                $display("[TB] FAIL rand_alu_ready c%0d: got %b expected %b", cyc, alu_ready, expAlu);
            end
            checks++;
            if (mem_ready !== expMem) begin
                failures++;
                $display("[TB] FAIL rand_mem_ready c%0d: got %b expected %b", cyc, mem_ready, expMem);
            end
            checks++;
            if (regWrite !== expWrite) begin
                failures++;
                $display("[TB] FAIL rand_regWrite c%0d: got %b expected %b", cyc, regWrite, expWrite);
            end
            checks++;
            if (rd !== expRd || writeData !== expData) begin
                failures++;
                $display("[TB] FAIL rand_head c%0d: got rd=%0d data=%h expected rd=%0d data=%h",
                         cyc, rd, writeData, expRd, expData);
            end
            checks++;
            if (pending_mask !== expMask) begin
                failures++;
                $display("[TB] FAIL rand_mask c%0d: got %h expected %h", cyc, pending_mask, expMask);
            end
            checks++;
            if (fifo_count !== q.size()) begin
                failures++;
                $display("[TB] FAIL rand_count c%0d: got %0d expected %0d", cyc, fifo_count, q.size());
            end

            aluTook = expAlu;
            memTook = expMem;
            if (expWrite) void'(q.pop_front());
            if (expAlu && alu_rd != '0) begin
                tmp.rd = alu_rd;
                tmp.data = alu_data;
                q.push_back(tmp);
            end
            if (expMem && mem_rd != '0) begin
                tmp.rd = mem_rd;
                tmp.data = mem_data;
                q.push_back(tmp);
            end
            if (alu_valid && mem_valid && !modelFull) modelLast = expAlu ? ALU : MEM;
            nextCycle();
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        wb_stall  = 1'b0;
        for (int i = 0; i <= DEPTH; i++) nextCycle();
        checks++;
        if (fifo_count !== 0) begin
            failures++;
            $display("[TB] FAIL rand_drain: got %0d expected 0", fifo_count);
        end
    endtask

    initial begin
        $display("[TB] starting regfile_wb_arbiter bench");
        test_reset();
        test_single_alu();
        test_conflict();
        test_full();
        test_x0();
        test_same_rd();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
